// File: rtl/pipe_pkg.sv
// Shared definitions for the destination-tracking pipeline.
//   IDX_W  : register index width
//   NODST  : index carried by bubbles and no-write instructions (R0 is hard-zero)
//   CNT_W  : stall-cycle counter width
//   slot_t : per-stage record {valid, wen, idx}
package pipe_pkg;

  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 16;

  localparam logic [IDX_W-1:0] NODST = '0;

  typedef struct packed {
    logic             valid;
    logic             wen;
    logic [IDX_W-1:0] idx;
  } slot_t;

  localparam slot_t BUBBLE = '{valid: 1'b0, wen: 1'b0, idx: NODST};

  // A no-write instruction carries NODST so it can never match in the dependency checker.
  function automatic slot_t make_slot(input logic wen, input logic [IDX_W-1:0] idx);
    slot_t s;
    s.valid = 1'b1;
    s.wen   = wen;
    s.idx   = wen ? idx : NODST;
    return s;
  endfunction

endpackage

// File: rtl/dst_track_pipe_if.sv
// Decode-side and stage-tracking signals of dst_track_pipe.
//   master : driven by decode / dependency checker / branch unit / perf monitor
//   slave  : the tracking pipeline itself
// Inputs to the pipe : D_valid, D_dst_idx, D_wen, D_stall, E_flush, stall_cnt_clr
// Outputs of the pipe: D_hold, {E,M,WB}_dst_idx, {E,M,WB}_valid, WB_wen, stall_cnt
interface dst_track_pipe_if;
  import pipe_pkg::*;

  logic             D_valid;
  logic [IDX_W-1:0] D_dst_idx;
  logic             D_wen;
  logic             D_stall;
  logic             E_flush;
  logic             stall_cnt_clr;

  logic             D_hold;
  logic [IDX_W-1:0] E_dst_idx;
  logic [IDX_W-1:0] M_dst_idx;
  logic [IDX_W-1:0] WB_dst_idx;
  logic             E_valid;
  logic             M_valid;
  logic             WB_valid;
  logic             WB_wen;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output D_valid, D_dst_idx, D_wen, D_stall, E_flush, stall_cnt_clr,
    input  D_hold, E_dst_idx, M_dst_idx, WB_dst_idx,
    input  E_valid, M_valid, WB_valid, WB_wen, stall_cnt
  );

  modport slave (
    input  D_valid, D_dst_idx, D_wen, D_stall, E_flush, stall_cnt_clr,
    output D_hold, E_dst_idx, M_dst_idx, WB_dst_idx,
    output E_valid, M_valid, WB_valid, WB_wen, stall_cnt
  );

endinterface

// File: rtl/dst_stage_slot.sv
// One pipeline stage slot holding {valid, wen, idx} of the instruction in that stage.
//   clk      : clock
//   rst      : synchronous active-high reset, forces a bubble
//   load     : capture slot_in at the next edge
//   bubble   : force a bubble at the next edge (wins over load)
//   slot_in  : incoming record
//   slot_out : registered record
module dst_stage_slot
  import pipe_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  bubble,
  input  slot_t slot_in,
  output slot_t slot_out
);

  slot_t slot_q;

  // Bubbles always carry NODST, so a squashed slot never exposes a stale index.
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      slot_q <= BUBBLE;
    end else if (load) begin
      slot_q <= slot_in;
    end
  end

  assign slot_out = slot_q;

endmodule

// File: rtl/dst_track_pipe.sv
// Tracks the destination register of each in-flight instruction through E, M and WB.
// The E/M/WB indices feed the decode dependency checker, whose D_stall comes back
// combinationally in the same cycle. A stall or a flush puts a bubble into E; a stall
// (without flush) also holds the F/D register. Held cycles are counted, saturating.
//   clk, rst              : clock, synchronous active-high reset
//   pif.D_*               : decode instruction and hazard status
//   pif.E_flush           : branch in E squashes decode
//   pif.stall_cnt_clr     : clears the stall counter
//   pif.D_hold            : hold F/D this cycle (combinational)
//   pif.{E,M,WB}_dst_idx  : stage destinations, pif.{E,M,WB}_valid : stage occupancy
//   pif.WB_wen            : register-file write enable
//   pif.stall_cnt         : saturating count of held cycles
module dst_track_pipe
  import pipe_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  dst_track_pipe_if.slave pif
);

  logic             d_hold;
  logic             e_load;
  slot_t            d_slot;
  slot_t            e_slot;
  slot_t            m_slot;
  slot_t            wb_slot;
  logic [CNT_W-1:0] stall_cnt_q;

  // Flush outranks stall: the decode instruction is squashed, so there is nothing to hold.
  // Reset also masks the hold so no residual stall is seen while the pipe is being cleared.
  assign d_hold = pif.D_valid & pif.D_stall & ~pif.E_flush & ~rst;
  assign e_load = pif.D_valid & ~pif.D_stall & ~pif.E_flush;
  assign d_slot = make_slot(pif.D_wen, pif.D_dst_idx);

  dst_stage_slot u_e_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (e_load),
    .bubble   (~e_load),
    .slot_in  (d_slot),
    .slot_out (e_slot)
  );

  // M and WB never stall; they advance every cycle.
  dst_stage_slot u_m_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b1),
    .bubble   (1'b0),
    .slot_in  (e_slot),
    .slot_out (m_slot)
  );

  dst_stage_slot u_wb_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b1),
    .bubble   (1'b0),
    .slot_in  (m_slot),
    .slot_out (wb_slot)
  );

  // Priority: rst, then clear, then saturating increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (pif.stall_cnt_clr) begin
      stall_cnt_q <= '0;
    end else if (d_hold && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign pif.D_hold     = d_hold;
  assign pif.E_dst_idx  = e_slot.idx;
  assign pif.M_dst_idx  = m_slot.idx;
  assign pif.WB_dst_idx = wb_slot.idx;
  assign pif.E_valid    = e_slot.valid;
  assign pif.M_valid    = m_slot.valid;
  assign pif.WB_valid   = wb_slot.valid;
  assign pif.WB_wen     = wb_slot.valid & wb_slot.wen & ~rst;
  assign pif.stall_cnt  = stall_cnt_q;

endmodule
